// File: rtl/avalon_ram_agent_pkg.sv
// Shared types and constants for the Avalon-MM RAM agent.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package avalon_ram_agent_pkg;

  // Transfer FSM: accept in IDLE, stall in WAIT, complete in ACK.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } avalon_agent_state_t;

  // Wait-state counter width; covers WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  // Unsigned window test; addresses below base wrap high and fail.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] window_bytes);
    return (addr - base) < window_bytes;
  endfunction

endpackage

// File: rtl/avalon_interface.sv
// Avalon-MM waitrequest-style bus bundle between master bridge and agent.
// Latency: none (wires only).
// Backpressure: agent stalls the master through waitrequest.
interface avalon_interface;
  logic [31:0] addr;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave (
    input  addr, byteenable, read, write, writedata,
    output readdata, waitrequest
  );

  modport master (
    output addr, byteenable, read, write, writedata,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/avalon_agent_ram_bank.sv
// Single-port word RAM with per-byte-lane write enables and registered read.
// Latency: read data valid one cycle after rd_en; writes land at the clock edge.
// Backpressure: none; caller never reads and writes in the same cycle.
module avalon_agent_ram_bank #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes and enabled registered read; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/avalon_ram_agent.sv
// Avalon-MM agent fronting a byte-enabled on-chip RAM with programmable wait states.
// Latency: request first seen in cycle N completes (waitrequest low) in cycle N+1+WAIT_STATES.
// Backpressure: waitrequest held high except the single ACK cycle; an IDLE turnaround follows every ACK.
module avalon_ram_agent
  import avalon_ram_agent_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  avalon_interface.slave   s_avalon,
  output logic             out_of_range,
  output logic             protocol_error,
  input  logic             clear_flags
);

  localparam int               AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      WINDOW_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] WS_LOAD      = CNT_W'(WAIT_STATES);

  avalon_agent_state_t state, state_nx;
  logic [CNT_W-1:0]    cnt;

  // Request captured at acceptance; later bus changes are ignored.
  logic [AW-1:0] idx_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          op_read_q;
  logic          in_range_q;

  logic          req;
  logic          accept;
  logic          in_range_in;
  logic [31:0]   offset;
  logic [AW-1:0] idx_in;

  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;

  assign req         = s_avalon.read | s_avalon.write;
  assign accept      = (state == IDLE) && req;
  assign offset      = s_avalon.addr - BASE_ADDR;
  assign in_range_in = addr_in_window(s_avalon.addr, BASE_ADDR, WINDOW_BYTES);
  assign idx_in      = offset[AW+1:2];

  // Next-state logic: WAIT is skipped entirely when there are no wait states.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WAIT_STATES > 0) ? WAIT : ACK;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and wait counter; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept)              cnt <= WS_LOAD;
      else if (state == WAIT)  cnt <= cnt - CNT_W'(1);
    end
  end

  // Capture the request; read takes priority when read and write are both high.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= idx_in;
      be_q       <= s_avalon.byteenable;
      wdata_q    <= s_avalon.writedata;
      op_read_q  <= s_avalon.read;
      in_range_q <= in_range_in;
    end
  end

  // Sticky error flags; a set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_of_range   <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (accept && !in_range_in)                   out_of_range <= 1'b1;
      else if (clear_flags)                         out_of_range <= 1'b0;
      if (accept && s_avalon.read && s_avalon.write) protocol_error <= 1'b1;
      else if (clear_flags)                         protocol_error <= 1'b0;
    end
  end

  // Read is launched on the edge into ACK; in IDLE the latch is not yet loaded, so use the live index.
  assign ram_addr = (state == IDLE) ? idx_in : idx_q;
  assign ram_rd   = (state_nx == ACK) && (state != ACK);
  assign ram_be   = (state == ACK && !op_read_q && in_range_q) ? be_q : 4'b0000;

  avalon_agent_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .addr  (ram_addr),
    .rd_en (ram_rd),
    .wr_be (ram_be),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign s_avalon.waitrequest = (state != ACK);
  assign s_avalon.readdata    = (state == ACK && op_read_q && in_range_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Self-checking bench: two agents (2 and 0 wait states) driven by a simple Avalon master.
// Expected responses are queued at issue and checked by per-agent monitors on each ACK.
// Monitors also require readdata to be zero in every stalled cycle.
module tb_avalon_ram_agent;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          is_read;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, clr_a, clr_b;
  logic oor_a, perr_a, oor_b, perr_b;

  logic [31:0] m_addr [2];
  logic [3:0]  m_be   [2];
  logic        m_rd   [2];
  logic        m_wr   [2];
  logic [31:0] m_wd   [2];

  avalon_interface av_a ();
  avalon_interface av_b ();

  assign av_a.addr       = m_addr[0];
  assign av_a.byteenable = m_be[0];
  assign av_a.read       = m_rd[0];
  assign av_a.write      = m_wr[0];
  assign av_a.writedata  = m_wd[0];
  assign av_b.addr       = m_addr[1];
  assign av_b.byteenable = m_be[1];
  assign av_b.read       = m_rd[1];
  assign av_b.write      = m_wr[1];
  assign av_b.writedata  = m_wd[1];

  avalon_ram_agent #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h8000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .s_avalon(av_a),
    .out_of_range(oor_a), .protocol_error(perr_a), .clear_flags(clr_a)
  );

  avalon_ram_agent #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) dut_b (
    .clk(clk), .rst(rst_b), .s_avalon(av_b),
    .out_of_range(oor_b), .protocol_error(perr_b), .clear_flags(clr_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic wreq(input int d);
    return (d == 0) ? av_a.waitrequest : av_b.waitrequest;
  endfunction

  // Monitor for agent A (2 wait states).
  always @(negedge clk) begin
    if (av_a.waitrequest === 1'b0) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_ack: ack at cycle %0d with no request outstanding", cyc);
      end else begin
        ea = q_a.pop_front();
        check("a_ack_cycle", cyc, ea.cyc);
        if (ea.is_read) check("a_readdata", av_a.readdata, ea.data);
      end
    end else begin
      check("a_readdata_stalled", av_a.readdata, 32'h0);
    end
  end

  // Monitor for agent B (0 wait states).
  always @(negedge clk) begin
    if (av_b.waitrequest === 1'b0) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_ack: ack at cycle %0d with no request outstanding", cyc);
      end else begin
        eb = q_b.pop_front();
        check("b_ack_cycle", cyc, eb.cyc);
        if (eb.is_read) check("b_readdata", av_b.readdata, eb.data);
      end
    end else begin
      check("b_readdata_stalled", av_b.readdata, 32'h0);
    end
  end

  // Master transfer; called just after a rising edge, returns just after the ACK edge.
  task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
    exp_t e;
    int   n;
    m_addr[d] = addr;
    m_be[d]   = be;
    m_rd[d]   = rd;
    m_wr[d]   = wr;
    m_wd[d]   = wd;
    e.data    = exp;
    e.cyc     = cyc + 1 + ((d == 0) ? 2 : 0);
    e.is_read = rd;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wreq(d) !== 1'b0 && n < 40);
    if (wreq(d) !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL xfer_timeout: agent %0d addr %h got no ACK within 40 cycles", d, addr);
    end
    @(posedge clk);
    #1;
    m_rd[d] = 1'b0;
    m_wr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 32'h0;
      m_be[i]   = 4'h0;
      m_rd[i]   = 1'b0;
      m_wr[i]   = 1'b0;
      m_wd[i]   = 32'h0;
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_waitrequest", av_a.waitrequest, 1);
    check("a_rst_readdata",    av_a.readdata, 0);
    check("a_rst_oor",         oor_a, 0);
    check("a_rst_perr",        perr_a, 0);
    check("b_rst_waitrequest", av_b.waitrequest, 1);
    check("b_rst_readdata",    av_b.readdata, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    // Write then read back, ACK at N+3.
    xfer(0, 0, 1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0);
    xfer(0, 1, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF);
    // Single byte lane 2.
    xfer(0, 0, 1, 32'h8000_0010, 4'b0100, 32'h00AA_0000, 32'h0);
    xfer(0, 1, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAA_BEEF);
    // byteenable=0 is a no-op write.
    xfer(0, 0, 1, 32'h8000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0);
    xfer(0, 1, 0, 32'h8000_0012, 4'hF, 32'h0, 32'hDEAA_BEEF);
    // Last word of the window is in range.
    xfer(0, 0, 1, 32'h8000_0FFC, 4'hF, 32'h0BAD_F00D, 32'h0);
    xfer(0, 1, 0, 32'h8000_0FFC, 4'hF, 32'h0, 32'h0BAD_F00D);
    check("a_oor_in_window", oor_a, 0);

    // Out of range below and above the window; the high write aliases word 0 and must be dropped.
    xfer(0, 0, 1, 32'h8000_0000, 4'hF, 32'h1234_5678, 32'h0);
    xfer(0, 1, 0, 32'h7FFF_FFFC, 4'hF, 32'h0, 32'h0);
    xfer(0, 0, 1, 32'h8000_1000, 4'hF, 32'hCAFE_F00D, 32'h0);
    check("a_oor_set", oor_a, 1);
    xfer(0, 1, 0, 32'h8000_0000, 4'hF, 32'h0, 32'h1234_5678);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    check("a_oor_cleared", oor_a, 0);

    // Set and clear in the same cycle: set wins.
    clr_a = 1'b1;
    fork
      xfer(0, 1, 0, 32'h8000_2000, 4'hF, 32'h0, 32'h0);
      begin
        @(posedge clk);
        #1;
        clr_a = 1'b0;
      end
    join
    check("a_oor_set_wins", oor_a, 1);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    check("a_oor_cleared2", oor_a, 0);

    // Read and write together: handled as a read, RAM untouched.
    check("a_perr_before", perr_a, 0);
    xfer(0, 1, 1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF, 32'h1234_5678);
    check("a_perr_set", perr_a, 1);
    check("a_perr_no_oor", oor_a, 0);
    xfer(0, 1, 0, 32'h8000_0000, 4'hF, 32'h0, 32'h1234_5678);

    // Reset during WAIT of a write: no ACK, no commit.
    xfer(0, 0, 1, 32'h8000_0020, 4'hF, 32'h0000_0055, 32'h0);
    m_addr[0] = 32'h8000_0020;
    m_be[0]   = 4'hF;
    m_wd[0]   = 32'h0000_0001;
    m_wr[0]   = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    check("a_rst_mid_waitrequest", av_a.waitrequest, 1);
    check("a_rst_mid_readdata", av_a.readdata, 0);
    m_wr[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("a_rst_mid_perr_cleared", perr_a, 0);
    @(posedge clk);
    #1;
    xfer(0, 1, 0, 32'h8000_0020, 4'hF, 32'h0, 32'h0000_0055);

    // Zero wait states, back-to-back: ACK at N+1, one ACK per request.
    xfer(1, 0, 1, 32'h8000_0040, 4'hF, 32'hA5A5_A5A5, 32'h0);
    xfer(1, 1, 0, 32'h8000_0040, 4'hF, 32'h0, 32'hA5A5_A5A5);
    xfer(1, 0, 1, 32'h8000_0044, 4'hF, 32'h1111_2222, 32'h0);
    xfer(1, 1, 0, 32'h8000_0040, 4'hF, 32'h0, 32'hA5A5_A5A5);
    xfer(1, 1, 0, 32'h8000_0044, 4'hF, 32'h0, 32'h1111_2222);
    xfer(1, 1, 0, 32'h8000_0040, 4'hF, 32'h0, 32'hA5A5_A5A5);
    check("b_oor", oor_b, 0);

    repeat (5) @(posedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
